change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter AMT_W, default 8, the width of the change amount in currency units.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, the maximum REQ-state cycles allowed without coin_ack.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port change_valid  input  1  one-cycle strobe; change_amount is valid.
REQ-006 SHALL have port change_amount  input  AMT_W  change owed, from the upstream vending FSM.
REQ-007 SHALL have port coin_ack  input  1  hopper confirms one coin ejected.
REQ-008 SHALL have port coin_req  output  1  request to the hopper to eject one coin of coin_sel.
REQ-009 SHALL have port coin_sel  output  2  coin denomination: 00=1, 01=5, 10=10, 11=20.
REQ-010 SHALL have port busy  output  1  high in REQ, GAP and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when all change is paid.
REQ-012 SHALL have port fault  output  1  sticky hopper-timeout flag.
REQ-013 SHALL have port remaining  output  AMT_W  amount still owed.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, GAP, DONE and FAULT, with all outputs registered.
REQ-015 SHALL, in IDLE with change_valid=1 and amount=0, load remaining<=0 and go to DONE; no coin_req is issued.
REQ-016 SHALL, in IDLE with change_valid=1 and amount>0, load remaining<=amount, load coin_sel<=greedy(amount) and go to REQ; coin_req rises the next cycle.
REQ-017 SHALL define greedy(x) as the largest denomination in {20,10,5,1} that is <= x.
REQ-018 SHALL, in REQ, hold coin_req=1 and coin_sel stable, and increment the timeout counter each cycle.
REQ-019 SHALL, in REQ with coin_ack=1, set remaining<=remaining-value(coin_sel) and clear the timeout counter.
REQ-020 SHALL then go to DONE if the new remaining is 0, or to GAP otherwise.
REQ-021 SHALL, in GAP, hold coin_req=0 for exactly one cycle, set coin_sel<=greedy(remaining) and go to REQ.
REQ-022 SHALL, in DONE, pulse done=1 for one cycle, hold coin_req=0 and return to IDLE.
REQ-023 SHALL, when the timeout counter reaches ACK_TIMEOUT in REQ without coin_ack, go to FAULT.
REQ-024 SHALL let coin_ack win if it arrives in the same cycle the counter reaches ACK_TIMEOUT.
REQ-025 SHALL, in FAULT, hold fault=1, coin_req=0 and busy=0, keep remaining frozen, and stay there until rst.
REQ-026 SHALL ignore change_valid outside IDLE; no queuing.
REQ-027 SHALL ignore coin_ack outside REQ.
REQ-028 SHALL never underflow remaining, by construction of greedy().
REQ-029 SHALL size the timeout counter to clog2(ACK_TIMEOUT+1) bits and saturate it.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE with coin_req=0, coin_sel=00, busy=0, done=0, fault=0, remaining=0 and counter=0.
REQ-031 SHALL abandon any dispense in progress on rst mid-operation with no further coin_req, and SHALL ignore coin_ack during reset.

Structure
REQ-032 SHALL place the denomination values (1, 5, 10, 20), the coin_sel encodings and the FSM state encodings in shared package vend_pkg.
REQ-033 SHALL place greedy() and value() in combinational sub-module change_coin_picker (input amount, outputs coin_sel and coin value).

Verification
REQ-034 SHALL verify: valid with amount 37 and immediate acks -> coin_sel sequence 11,10,01,00,00; remaining 37→17→7→2→1→0; done after the last ack.
REQ-035 SHALL verify: valid with amount 0 -> done=1 exactly 1 cycle later; coin_req never asserted.
REQ-036 SHALL verify: amount 5 and coin_ack never asserted -> fault=1 after 15 REQ cycles; coin_req low; remaining=5 held until rst.
REQ-037 SHALL verify: second valid (amount 9) during a 20-unit dispense -> ignored; exactly one coin 11 dispensed; done once.
REQ-038 SHALL verify: rst asserted in REQ while paying 30 -> next cycle IDLE with all outputs at reset values; a subsequent valid with amount 6 dispenses 01,00.
REQ-039 SHALL verify: coin_ack arriving on the 15th REQ cycle -> accepted; no fault.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: coin values, coin_sel encodings and dispenser FSM states
package vend_pkg;
    localparam int VAL_1  = 1;
    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;
    localparam int VAL_20 = 20;
    typedef enum logic [1:0] {
        COIN_1  = 2'b00,
        COIN_5  = 2'b01,
        COIN_10 = 2'b10,
        COIN_20 = 2'b11
    } coin_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_e;
endpackage

// File: rtl/change_coin_picker.sv
// change_coin_picker: largest coin not exceeding the amount, and its value
module change_coin_picker
    import vend_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] amount_i,
    output coin_e            coin_sel_o,
    output logic [AMT_W-1:0] coin_val_o
);
    logic [31:0] amt;
    assign amt = 32'(amount_i);
    // greedy pick, then map the chosen coin to its value
    always_comb begin
        coin_sel_o = amt >= 32'(VAL_20) ? COIN_20 :
                     amt >= 32'(VAL_10) ? COIN_10 :
                     amt >= 32'(VAL_5)  ? COIN_5  : COIN_1;
        coin_val_o = AMT_W'(coin_sel_o == COIN_20 ? VAL_20 :
                            coin_sel_o == COIN_10 ? VAL_10 :
                            coin_sel_o == COIN_5  ? VAL_5  : VAL_1);
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays change one coin at a time through a hopper handshake
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    input  logic             coin_ack,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [AMT_W-1:0] remaining_q, remaining_d, rem_sub, pick_in, pick_val;
    coin_e            coin_sel_q, coin_sel_d, pick_sel;
    logic             coin_req_q, coin_req_d, busy_q, busy_d;
    logic             done_q, done_d, fault_q, fault_d, timeout;

    // In REQ the remaining amount is unchanged since the coin was chosen,
    // so the picker's value output equals the value of the coin on offer.
    assign pick_in = (state_q == S_IDLE) ? change_amount : remaining_q;

    change_coin_picker #(.AMT_W(AMT_W)) u_picker (
        .amount_i   (pick_in),
        .coin_sel_o (pick_sel),
        .coin_val_o (pick_val)
    );

    assign rem_sub = remaining_q - pick_val;
    assign cnt_nxt = (cnt_q == CNT_W'(ACK_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    assign timeout = cnt_nxt == CNT_W'(ACK_TIMEOUT);

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            remaining_q <= '0;
            coin_sel_q  <= COIN_1;
            coin_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            coin_sel_q  <= coin_sel_d;
            coin_req_q  <= coin_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    // next state; an ack beats a timeout landing on the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (change_valid) state_d = (change_amount == '0) ? S_DONE : S_REQ;
            S_REQ:   if (coin_ack) state_d = (rem_sub == '0) ? S_DONE : S_GAP;
                     else if (timeout) state_d = S_FAULT;
            S_GAP:   state_d = S_REQ;
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // next values of the datapath and of the flags, taken from the next state
    always_comb begin
        remaining_d = (state_q == S_IDLE && change_valid) ? change_amount :
                      (state_q == S_REQ && coin_ack)      ? rem_sub : remaining_q;
        coin_sel_d  = ((state_q == S_IDLE && change_valid && change_amount != '0) ||
                       state_q == S_GAP) ? pick_sel : coin_sel_q;
        cnt_d       = (state_q == S_REQ && !coin_ack) ? cnt_nxt : '0;
        coin_req_d  = state_d == S_REQ;
        busy_d      = state_d == S_REQ || state_d == S_GAP || state_d == S_DONE;
        done_d      = state_d == S_DONE;
        fault_d     = state_d == S_FAULT;
    end

    assign coin_req  = coin_req_q;
    assign coin_sel  = coin_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = remaining_q;
endmodule
